// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
//   XLEN          : machine word width
//   INSTR_NOP     : canonical no-op encoding (addi x0, x0, 0)
//   fetch_state_e : fetch sequencer states
//   fetch_entry_t : one buffered fetch, PC plus instruction word
//   word_align()  : clears the byte-offset bits of an address
package if_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO of fetch entries between the memory response path and the
// core-facing output. Head data is read combinationally (no output register).
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   flush          : drop all entries this cycle (takes priority over push/pop)
//   push, wdata    : write one entry
//   pop            : retire the head entry (ignored when empty)
//   rdata          : head entry, undefined when empty
//   full, empty    : occupancy flags
//   count          : number of valid entries
module if_fifo
  import if_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  fetch_entry_t                 wdata,
  input  logic                         pop,
  output fetch_entry_t                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;

  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !do_pop) begin
        cnt <= cnt + 1'b1;
      end else if (!push && do_pop) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Storage needs no reset; the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

  // A push into a full FIFO is only legal when the head leaves the same cycle.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      assert (!(push && full && !do_pop));
    end
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch prefetch unit. Issues word fetches to a variable-latency,
// in-order instruction memory, buffers returned words with their PCs and hands
// them to the core over a valid/ready handshake. A redirect restarts fetching
// at a new PC and discards everything buffered or still in flight.
// Ports:
//   clk_i, reset_i                 : clock, synchronous active-high reset
//   redirect_i, redirect_pc_i      : flush and restart at redirect_pc_i[31:2]
//   imem_req_o, imem_addr_o        : fetch request and word-aligned address
//   imem_gnt_i                     : request accepted this cycle
//   imem_rvalid_i, imem_rdata_i    : in-order response
//   instr_valid_o, instr_o,
//   instr_pc_o                     : FIFO head (instr/pc read 0 when empty)
//   instr_ready_i                  : core consumes the head
//
// state | meaning
// ------+-----------------------------------------------------------------
// RUN   | normal fetching; responses are buffered
// FLUSH | waiting for stale in-flight responses after a redirect; no requests
module if_prefetch_unit
  import if_pkg::*;
#(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   target_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_nxt;
  logic [OW-1:0] discard_cnt;
  logic [OW-1:0] discard_nxt;

  logic          gnt_fire;
  logic          push_en;
  logic          pop_en;
  logic          credit_ok;
  logic          slot_ok;
  logic [31:0]   credit_used;

  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign target_pc = word_align(redirect_pc_i);

  // Every granted request reserves a FIFO slot, so buffered + in-flight words
  // can never exceed DEPTH and the FIFO cannot overflow.
  assign credit_used = 32'(fifo_count) + 32'(outstanding);
  assign credit_ok   = credit_used < 32'(DEPTH);
  assign slot_ok     = outstanding < OW'(MAX_OUTSTANDING);

  assign imem_req_o  = !reset_i && (state == RUN) && !redirect_i && credit_ok && slot_ok;
  assign imem_addr_o = fetch_pc;
  assign gnt_fire    = imem_req_o && imem_gnt_i;

  // A response arriving with a redirect belongs to the old stream and is dropped.
  assign push_en = imem_rvalid_i && (discard_cnt == '0) && !redirect_i;
  assign pop_en  = instr_valid_o && instr_ready_i && !redirect_i;

  assign push_entry.pc    = resp_pc;
  assign push_entry.instr = imem_rdata_i;

  if_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .reset (reset_i),
    .flush (redirect_i),
    .push  (push_en),
    .wdata (push_entry),
    .pop   (pop_en),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? '0 : head_entry.instr;
  assign instr_pc_o    = fifo_empty ? '0 : head_entry.pc;

  always_comb begin
    outstanding_nxt = outstanding;
    case ({gnt_fire, imem_rvalid_i})
      2'b10:   outstanding_nxt = outstanding + 1'b1;
      2'b01:   outstanding_nxt = outstanding - 1'b1;
      default: outstanding_nxt = outstanding;
    endcase
  end

  // On a redirect every fetch still in flight after this cycle's response is
  // stale. No grant can coincide with a redirect, so that is just outstanding
  // less any response landing now.
  always_comb begin
    discard_nxt = discard_cnt;
    if (redirect_i) begin
      discard_nxt = imem_rvalid_i ? outstanding - 1'b1 : outstanding;
    end else if (imem_rvalid_i && (discard_cnt != '0)) begin
      discard_nxt = discard_cnt - 1'b1;
    end
  end

  // FLUSH lasts exactly as long as stale responses remain, so RUN resumes
  // (and the first new request goes out) the cycle after the last one lands.
  assign state_nxt = (discard_nxt != '0) ? FLUSH : RUN;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      discard_cnt <= discard_nxt;
      if (redirect_i) begin
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
      end else begin
        if (gnt_fire) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push_en) begin
          resp_pc <= resp_pc + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(imem_rvalid_i && (outstanding == '0)));
      assert (!(push_en && fifo_full && !pop_en));
      assert (credit_used <= 32'(DEPTH));
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
module tb_if_prefetch_unit;
  import if_pkg::*;

  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;

  always #5 clk = ~clk;

  if_prefetch_unit #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (RPC)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  int checks = 0;
  int errors = 0;

  // stimulus knobs
  int gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1, redir_pct = 0;
  logic        rst_req = 1'b1;
  logic        redir_req = 1'b0;
  logic [31:0] redir_target = '0;

  // memory model: in-order pending fetches with the cycle each may answer
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;

  // reference program-order stream the core should observe
  fetch_entry_t exp_q[$];
  logic [31:0]  model_pc = RPC;

  int          grant_cnt = 0;
  logic [31:0] last_grant_addr = '0;
  bit          saw_wrap = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'hA5A5_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req"},   32'(imem_req_o),    32'd0);
    chk({tag, "_addr"},  imem_addr_o,        RPC);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
    chk({tag, "_instr"}, instr_o,            32'd0);
    chk({tag, "_pc"},    instr_pc_o,         32'd0);
  endtask

  // One clock: observe the handshakes at negedge, then drive the next cycle.
  task automatic cycle();
    logic        fire;
    logic        rv;
    fetch_entry_t e;
    @(negedge clk);
    fire = imem_req_o && imem_gnt_i && !reset_i;
    rv   = imem_rvalid_i;
    if (fire) begin
      grant_cnt++;
      last_grant_addr = imem_addr_o;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rv && pend_addr.size() > 0) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (fire) begin
      pend_addr.push_back(last_grant_addr);
      pend_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)) - 1);
    end
    reset_i = rst_req;
    if (rst_req) begin
      pend_addr.delete();
      pend_due.delete();
      exp_q.delete();
      model_pc = RPC;
    end
    redirect_i    = !rst_req && (redir_req || ($urandom_range(99) < redir_pct));
    redirect_pc_i = redir_req ? redir_target : $urandom;
    if (redirect_i) begin
      exp_q.delete();
      model_pc = {redirect_pc_i[31:2], 2'b00};
    end
    imem_gnt_i    = ($urandom_range(99) < gnt_pct);
    instr_ready_i = ($urandom_range(99) < ready_pct);
    if (!rst_req && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_addr[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
    while (exp_q.size() < 8) begin
      e.pc    = model_pc;
      e.instr = mem_word(model_pc);
      exp_q.push_back(e);
      model_pc = model_pc + 32'd4;
    end
  endtask

  // monitor: request ordering/stability and the delivered instruction stream
  initial begin : monitor
    logic        prev_hold;
    logic [31:0] prev_addr;
    logic [31:0] exp_req_pc;
    logic [31:0] prev_gaddr;
    fetch_entry_t e;
    prev_hold  = 1'b0;
    prev_addr  = '0;
    exp_req_pc = RPC;
    prev_gaddr = '0;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        exp_req_pc = RPC;
        prev_hold  = 1'b0;
      end else begin
        if (prev_hold && !redirect_i) begin
          chk("req_held", 32'(imem_req_o), 32'd1);
          chk("addr_held", imem_addr_o, prev_addr);
        end
        if (redirect_i) begin
          chk("req_during_redirect", 32'(imem_req_o), 32'd0);
        end
        if (imem_req_o && imem_gnt_i) begin
          chk("grant_addr", imem_addr_o, exp_req_pc);
          if (prev_gaddr == 32'hFFFF_FFFC && imem_addr_o == 32'h0) saw_wrap = 1'b1;
          prev_gaddr = imem_addr_o;
          exp_req_pc = exp_req_pc + 32'd4;
        end
        if (redirect_i) exp_req_pc = {redirect_pc_i[31:2], 2'b00};
        prev_hold = imem_req_o && !imem_gnt_i;
        prev_addr = imem_addr_o;
        if (!instr_valid_o) begin
          chk("empty_instr", instr_o, 32'd0);
          chk("empty_pc", instr_pc_o, 32'd0);
        end else if (instr_ready_i && !redirect_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stream_underflow actual=pop required=none");
          end else begin
            e = exp_q.pop_front();
            chk("instr_pc", instr_pc_o, e.pc);
            chk("instr", instr_o, e.instr);
          end
        end
      end
    end
  end

  initial begin : main
    int          g0;
    int          n;
    logic [31:0] held;
    reset_i       = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    instr_ready_i = 1'b0;

    repeat (3) cycle();
    check_reset("por");

    // zero-wait memory, core always ready: one word per cycle after fill
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
    rst_req = 1'b0;
    cycle();
    #1;
    chk("first_req", 32'(imem_req_o), 32'd1);
    chk("first_addr", imem_addr_o, RPC);
    repeat (3) cycle();
    repeat (16) begin
      cycle();
      #1;
      chk("zero_wait_valid", 32'(instr_valid_o), 32'd1);
    end

    // core stalled: exactly DEPTH words buffered, then requests stop
    ready_pct = 0;
    rst_req = 1'b1;
    cycle();
    cycle();
    rst_req = 1'b0;
    grant_cnt = 0;
    cycle();
    repeat (20) cycle();
    #1;
    chk("buffered_grants", 32'(grant_cnt), 32'(DEPTH));
    chk("buffered_req_low", 32'(imem_req_o), 32'd0);
    chk("buffered_valid", 32'(instr_valid_o), 32'd1);
    chk("buffered_head_pc", instr_pc_o, RPC);

    // resume, then hold grant low for 3 cycles
    ready_pct = 100;
    repeat (6) cycle();
    gnt_pct = 0;
    repeat (3) cycle();
    #1;
    held = imem_addr_o;
    chk("hold_req_up", 32'(imem_req_o), 32'd1);
    chk("hold_addr_model", held, RPC + 32'(grant_cnt) * 32'd4);
    repeat (3) begin
      cycle();
      #1;
      chk("hold_req", 32'(imem_req_o), 32'd1);
      chk("hold_addr", imem_addr_o, held);
    end
    gnt_pct = 100;
    repeat (10) cycle();

    // random traffic with occasional redirects
    gnt_pct = 70; ready_pct = 70; lat_min = 1; lat_max = 4; redir_pct = 3;
    repeat (1500) cycle();

    // reset mid-burst
    rst_req = 1'b1;
    cycle();
    cycle();
    check_reset("mid");
    gnt_pct = 100; ready_pct = 100; lat_min = 6; lat_max = 6; redir_pct = 0;
    rst_req = 1'b0;
    cycle();
    #1;
    chk("mid_first_req", 32'(imem_req_o), 32'd1);
    chk("mid_first_addr", imem_addr_o, RPC);

    // two fetches in flight, then redirect to 0x103
    cycle();
    cycle();
    redir_target = 32'h0000_0103;
    redir_req = 1'b1;
    cycle();
    redir_req = 1'b0;
    cycle();
    #1;
    chk("flush_req_low", 32'(imem_req_o), 32'd0);
    chk("flush_fifo_empty", 32'(instr_valid_o), 32'd0);
    g0 = grant_cnt;
    n = 0;
    while (grant_cnt == g0 && n < 20) begin
      cycle();
      n++;
    end
    chk("redirect_grant_seen", (grant_cnt > g0) ? 32'd1 : 32'd0, 32'd1);
    chk("redirect_first_addr", last_grant_addr, 32'h0000_0100);
    n = 0;
    #1;
    while (!instr_valid_o && n < 20) begin
      cycle();
      #1;
      n++;
    end
    chk("redirect_valid_seen", 32'(instr_valid_o), 32'd1);
    chk("redirect_first_pc", instr_pc_o, 32'h0000_0100);

    // fetch address wrap through 0xFFFF_FFFC
    gnt_pct = 80; ready_pct = 80; lat_min = 1; lat_max = 3;
    redir_target = 32'hFFFF_FFF1;
    redir_req = 1'b1;
    cycle();
    redir_req = 1'b0;
    saw_wrap = 1'b0;
    repeat (40) cycle();
    chk("pc_wrap_seen", 32'(saw_wrap), 32'd1);

    // heavier random traffic
    gnt_pct = 60; ready_pct = 50; lat_min = 1; lat_max = 5; redir_pct = 8;
    repeat (2000) cycle();
    redir_pct = 0;
    repeat (10) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the core's instruction decode and control path.
- Replaces the direct program-counter-to-instruction-memory path with a fetch unit that talks to a variable-latency instruction memory through a request/grant/response handshake.
- Buffers fetched words and their PCs in a small FIFO and presents them to the core with a valid/ready handshake.
- Supports a one-cycle redirect (branch/jal/jalr target) that flushes buffered and in-flight fetches.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- MAX_OUTSTANDING, 2, maximum granted requests still awaiting a response; at least 1.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- redirect_i  in  1  flush and restart fetch at redirect_pc_i
- redirect_pc_i  in  32  new fetch address; bits [1:0] ignored
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  word-aligned fetch address
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; responses return in request order
- imem_rdata_i  in  32  response instruction word
- instr_valid_o  out  1  FIFO head valid
- instr_o  out  32  head instruction; 0 when empty
- instr_pc_o  out  32  head PC; 0 when empty
- instr_ready_i  in  1  core consumes head

Behaviour:
Clock and reset (already decided):
- One clock, clk_i; reset_i is synchronous and active-high.
- On reset: fetch_pc = resp_pc = RESET_PC; FIFO empty; outstanding = 0; discard_cnt = 0; state = RUN.
- Output reset values: imem_req_o = 0, imem_addr_o = RESET_PC, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0.
- Reset mid-transaction abandons all in-flight fetches. The memory is reset on the same reset_i, so no stale response arrives after reset.

States:
- RUN: normal fetching.
- FLUSH: discarding stale responses after a redirect.

Request issue:
- imem_req_o = (state == RUN) && !redirect_i && (fifo_count + outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
- imem_addr_o = fetch_pc.
- Handshake completes on imem_req_o && imem_gnt_i: outstanding++, fetch_pc += 4 (32-bit wrap from 0xFFFF_FFFC to 0).
- Once raised, imem_req_o and imem_addr_o stay stable until grant. The only exception is redirect_i, which may drop the request.

Response:
- On imem_rvalid_i: outstanding--.
- If discard_cnt > 0: discard_cnt-- and the word is dropped.
- Otherwise: push {resp_pc, imem_rdata_i} into the FIFO, then resp_pc += 4.
- The credit rule guarantees the FIFO never overflows. A push while full is an assertion failure.

Output:
- instr_valid_o = !fifo_empty.
- Pop on instr_valid_o && instr_ready_i.
- Push and pop in the same cycle are both allowed, including when the FIFO is full (pop frees a slot) or empty (the pushed word appears next cycle; no bypass, latency is 1 cycle from rvalid to instr_valid_o).

Redirect (highest priority):
- Effects in the cycle redirect_i is asserted:
  - fetch_pc = resp_pc = {redirect_pc_i[31:2], 2'b00}.
  - FIFO cleared; any pop in that cycle is ignored.
  - No grant can occur, because the request is suppressed.
- discard_cnt is set to the outstanding count after that cycle's response is accounted for: outstanding minus 1 if imem_rvalid_i is high, else outstanding. A same-cycle response is itself dropped.
- State goes to FLUSH if the new discard_cnt > 0, else stays in RUN.
- A redirect while in FLUSH updates the PCs only; discard_cnt keeps tracking outstanding.
- FLUSH returns to RUN in the cycle after discard_cnt reaches 0. The first new request is issued in that cycle.
- With no outstanding fetches, a redirect causes a request on the next cycle.

Counter widths:
- outstanding and discard_cnt: $clog2(MAX_OUTSTANDING+1) bits.
- fifo_count: $clog2(DEPTH+1) bits.

Decomposition:
- Package if_pkg holds:
  - XLEN = 32
  - INSTR_NOP = 32'h0000_0013
  - enum fetch_state_e {RUN, FLUSH}
  - packed struct fetch_entry_t {pc, instr}
- Sub-module if_fifo: synchronous FIFO of fetch_entry_t with DEPTH entries, providing push, pop, flush, full, empty and count outputs.

Test Plan:
- Zero-wait memory (gnt always 1, rvalid one cycle after grant), ready=1 → PCs 0, 4, 8, … appear on consecutive cycles after fill; instr_o equals the memory contents.
- instr_ready_i = 0 with DEPTH=4 → exactly 4 entries buffered, then imem_req_o stays low; raising ready resumes fetching in order with no lost or duplicated PC.
- gnt held low for 3 cycles → imem_req_o and imem_addr_o are held constant (e.g. 0x0000_0008) throughout; fetch_pc advances only on grant.
- Two requests outstanding, then redirect_i with redirect_pc_i = 0x0000_0103 → FIFO emptied, the two stale responses dropped, state FLUSH, first new request at 0x0000_0100, first instr_pc_o = 0x0000_0100.
- Redirect in the same cycle as imem_rvalid_i and a pop → that response is dropped, the pop is ignored, and discard_cnt equals the remaining outstanding count.
- reset_i asserted mid-burst → next cycle all outputs hold their reset values and the first request is at RESET_PC; also check fetch_pc wrap 0xFFFF_FFFC → 0x0000_0000.
